tsp_result_display: RTL and testbench



---
 rtl/tsp_disp_pkg.sv | 34 +++
 rtl/seg7_decoder.sv | 11 +
 rtl/tsp_result_display.sv | 146 ++++++++++++++
 tb/tb_tsp_result_display.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/tsp_disp_pkg.sv
// Shared types and constants for the TSP result display block.
// Holds the FSM state type, the segment constants and the 7-segment lookup.
package tsp_disp_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    UPDATE  = 2'd2
  } state_t;

  localparam logic [6:0]  SEG_BLANK = 7'h7F;
  localparam logic [6:0]  SEG_DASH  = 7'h3F;
  localparam int unsigned MAX_DISP  = 999999;

  // Active-low segment pattern {g,f,e,d,c,b,a} for one BCD digit.
  function automatic logic [6:0] seg_of(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Pure combinational BCD nibble to active-low 7-segment lookup.
module seg7_decoder
  import tsp_disp_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = seg_of(nibble);

endmodule

// File: rtl/tsp_result_display.sv
// TSP result display: accepts a binary best-tour cost, converts it to BCD with
// a sequential double-dabble and drives six active-low seven-segment digits
// plus four status LEDs.
// Optional build macro LEADING_ZERO_BLANK_EN blanks digits above the most
// significant non-zero digit (HEX0 is always shown).
module tsp_result_display
  import tsp_disp_pkg::*;
#(
  parameter int COST_W = 20,
  parameter int DIGITS = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [COST_W-1:0] cost_data,
  input  logic              solver_done,
  output logic [6:0]        HEX0,
  output logic [6:0]        HEX1,
  output logic [6:0]        HEX2,
  output logic [6:0]        HEX3,
  output logic [6:0]        HEX4,
  output logic [6:0]        HEX5,
  output logic [3:0]        LEDR
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(COST_W + 1);

  state_t             state_q, state_d;
  logic [COST_W-1:0]  bin_q, bin_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d, bcd_adj;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;          // overflow of the conversion in flight
  logic               shown_ovf_q, shown_ovf_d;
  logic               tog_q, tog_d;
  logic               done_q, done_d;
  logic [6:0]         hex_q [DIGITS];
  logic [6:0]         hex_d [DIGITS];
  logic [6:0]         seg_w [DIGITS];

  // Per-digit decoder on the BCD register and the add-3 correction step.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    seg7_decoder u_dec (
      .nibble (bcd_q[4*gi +: 4]),
      .seg    (seg_w[gi])
    );
    assign bcd_adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ? bcd_q[4*gi +: 4] + 4'd3
                                                            : bcd_q[4*gi +: 4];
  end

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is blanked when it and every digit above it are zero.
  logic [DIGITS-1:0] lead_blank;
  assign lead_blank[0] = 1'b0;
  for (genvar gi = 1; gi < DIGITS; gi++) begin : g_blank
    assign lead_blank[gi] = ~|bcd_q[BCD_W-1:4*gi];
  end
`endif

  // Next-state, datapath and handshake logic for the IDLE/CONVERT/UPDATE FSM.
  always_comb begin
    state_d     = state_q;
    bin_d       = bin_q;
    bcd_d       = bcd_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    shown_ovf_d = shown_ovf_q;
    tog_d       = tog_q;
    done_d      = solver_done;
    hex_d       = hex_q;
    in_ready    = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          bin_d   = cost_data;
          bcd_d   = '0;
          cnt_d   = CNT_W'(COST_W);
          ovf_d   = (32'(cost_data) > MAX_DISP);
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        bcd_d = {bcd_adj[BCD_W-2:0], bin_q[COST_W-1]};
        bin_d = {bin_q[COST_W-2:0], 1'b0};
        // A bit falling off the top BCD nibble means the value exceeds the
        // display; already covered by the compare, kept as a safety net.
        ovf_d = ovf_q | bcd_adj[BCD_W-1];
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = UPDATE;
      end
      UPDATE: begin
        for (int i = 0; i < DIGITS; i++) begin
          if (ovf_q) begin
            hex_d[i] = SEG_DASH;
          end else begin
`ifdef LEADING_ZERO_BLANK_EN
            hex_d[i] = lead_blank[i] ? SEG_BLANK : seg_w[i];
`else
            hex_d[i] = seg_w[i];
`endif
          end
        end
        shown_ovf_d = ovf_q;
        tog_d       = ~tog_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset blanks the display and aborts conversion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      bin_q       <= '0;
      bcd_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      shown_ovf_q <= 1'b0;
      tog_q       <= 1'b0;
      done_q      <= 1'b0;
      for (int i = 0; i < DIGITS; i++) hex_q[i] <= SEG_BLANK;
    end else begin
      state_q     <= state_d;
      bin_q       <= bin_d;
      bcd_q       <= bcd_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      shown_ovf_q <= shown_ovf_d;
      tog_q       <= tog_d;
      done_q      <= done_d;
      hex_q       <= hex_d;
    end
  end

  assign HEX0 = hex_q[0];
  assign HEX1 = hex_q[1];
  assign HEX2 = hex_q[2];
  assign HEX3 = hex_q[3];
  assign HEX4 = hex_q[4];
  assign HEX5 = hex_q[5];
  assign LEDR = {done_q, tog_q, shown_ovf_q, (state_q != IDLE)};

endmodule

// File: tb/tb_tsp_result_display.sv
// Testbench for tsp_result_display: table of costs with hand-computed
// seven-segment patterns, plus directed reset, busy and latency sequences.
// Compile with +define+LEADING_ZERO_BLANK_EN to check the blanking build.
module tb_tsp_result_display;

  localparam int COST_W = 20;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LZ = 7'h7F;
`else
  localparam logic [6:0] LZ = 7'h40;
`endif
  localparam logic [41:0] ALL_BLANK = {6{7'h7F}};
  localparam logic [41:0] ALL_DASH  = {6{7'h3F}};

  typedef struct {
    int unsigned cost;
    logic [41:0] hex;   // {HEX5..HEX0}
    logic        ovf;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [COST_W-1:0] cost_data;
  logic              solver_done;
  logic [6:0]        hex0, hex1, hex2, hex3, hex4, hex5;
  logic [3:0]        ledr;
  logic [41:0]       hex_all;

  int checks = 0;
  int errors = 0;
  logic exp_tog = 1'b0;

  assign hex_all = {hex5, hex4, hex3, hex2, hex1, hex0};

  tsp_result_display #(.COST_W(COST_W), .DIGITS(6)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .cost_data   (cost_data),
    .solver_done (solver_done),
    .HEX0        (hex0),
    .HEX1        (hex1),
    .HEX2        (hex2),
    .HEX3        (hex3),
    .HEX4        (hex4),
    .HEX5        (hex5),
    .LEDR        (ledr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Full transaction: accept at edge N, check busy window N+1..N+20, result at N+21.
  task automatic run_vec(input int unsigned cost, input logic [41:0] exp_hex, input logic exp_ovf);
    logic [41:0] prev_hex;
    int          busy_bad;
    @(negedge clk);
    chk("ready_before", 64'(in_ready), 64'd1);
    in_valid  = 1'b1;
    cost_data = COST_W'(cost);
    @(posedge clk);
    #1 in_valid = 1'b0;
    prev_hex = hex_all;
    busy_bad = 0;
    for (int k = 1; k <= COST_W; k++) begin
      @(posedge clk);
      #1;
      if (in_ready !== 1'b0 || hex_all !== prev_hex || ledr[0] !== 1'b1) busy_bad++;
    end
    @(posedge clk);
    #1;
    exp_tog = ~exp_tog;
    chk("busy_window", 64'(busy_bad), 64'd0);
    chk("hex", 64'(hex_all), 64'(exp_hex));
    chk("led_ovf", 64'(ledr[1]), 64'(exp_ovf));
    chk("led_tog", 64'(ledr[2]), 64'(exp_tog));
    chk("ready_after", 64'(in_ready), 64'd1);
    $display("vec cost=%0d hex=%h ledr=%b", cost, hex_all, ledr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[10];
    int   bad;
    vecs[0] = '{12345,   {LZ, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12}, 1'b0};
    vecs[1] = '{1000000, ALL_DASH,                                 1'b1};
    vecs[2] = '{999999,  {6{7'h10}},                               1'b0};
    vecs[3] = '{0,       {LZ, LZ, LZ, LZ, LZ, 7'h40},              1'b0};
    vecs[4] = '{305,     {LZ, LZ, LZ, 7'h30, 7'h40, 7'h12},        1'b0};
    vecs[5] = '{100000,  {7'h79, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}, 1'b0};
    vecs[6] = '{86,      {LZ, LZ, LZ, LZ, 7'h00, 7'h02},           1'b0};
    vecs[7] = '{1048575, ALL_DASH,                                 1'b1};
    vecs[8] = '{7,       {LZ, LZ, LZ, LZ, LZ, 7'h78},              1'b0};
    vecs[9] = '{999999,  {6{7'h10}},                               1'b0};

    rst = 1'b1; in_valid = 1'b0; cost_data = '0; solver_done = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_hex", 64'(hex_all), 64'(ALL_BLANK));
    chk("rst_ledr", 64'(ledr), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;

    // Basic conversion of 12345.
    run_vec(vecs[0].cost, vecs[0].hex, vecs[0].ovf);

    // Asynchronous reset mid-cycle: outputs return without a clock edge.
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    exp_tog = 1'b0;
    chk("arst_hex", 64'(hex_all), 64'(ALL_BLANK));
    chk("arst_ledr", 64'(ledr), 64'd0);
    chk("arst_ready", 64'(in_ready), 64'd1);
    @(negedge clk) rst = 1'b0;

    // Reset during CONVERT: no partial value ever reaches HEX.
    @(negedge clk);
    in_valid = 1'b1; cost_data = COST_W'(500000);
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("midrst_ready", 64'(in_ready), 64'd1);
    chk("midrst_ledr", 64'(ledr), 64'd0);
    @(negedge clk);
    @(negedge clk) rst = 1'b0;
    bad = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk);
      #1;
      if (hex_all !== ALL_BLANK || in_ready !== 1'b1) bad++;
    end
    chk("midrst_hold", 64'(bad), 64'd0);
    run_vec(7, {LZ, LZ, LZ, LZ, LZ, 7'h78}, 1'b0);

    // solver_done is registered with a single cycle of delay.
    @(negedge clk) solver_done = 1'b1;
    #1 chk("done_pre", 64'(ledr[3]), 64'd0);
    @(posedge clk);
    #1 chk("done_post", 64'(ledr[3]), 64'd1);
    @(negedge clk) solver_done = 1'b0;
    @(posedge clk);
    #1 chk("done_clr", 64'(ledr[3]), 64'd0);

    // Busy rejection: 42 accepted at N, 777 held until in_ready returns.
    @(negedge clk);
    in_valid = 1'b1; cost_data = COST_W'(42);
    @(posedge clk);
    #1 cost_data = COST_W'(777);
    repeat (COST_W + 1) @(posedge clk);
    #1;
    exp_tog = ~exp_tog;
    chk("busy_42", 64'(hex_all), 64'({LZ, LZ, LZ, LZ, 7'h19, 7'h24}));
    chk("busy_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (COST_W) @(posedge clk);
    #1;
    chk("busy_hold42", 64'(hex_all), 64'({LZ, LZ, LZ, LZ, 7'h19, 7'h24}));
    @(posedge clk);
    #1;
    exp_tog = ~exp_tog;
    chk("busy_777", 64'(hex_all), 64'({LZ, LZ, LZ, 7'h78, 7'h78, 7'h78}));
    chk("busy_tog", 64'(ledr[2]), 64'(exp_tog));
    $display("busy seq hex=%h ledr=%b", hex_all, ledr);

    // Table of costs, including overflow and boundary values.
    for (int v = 1; v < 10; v++) begin
      run_vec(vecs[v].cost, vecs[v].hex, vecs[v].ovf);
    end

    // Display holds its value with no new input.
    repeat (30) @(posedge clk);
    #1 chk("hold", 64'(hex_all), 64'({6{7'h10}}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
